// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one registered 4:1 data path among four requesters,
// with per-beat ack, bounded bursts and a valid/ready output register.
module mux4_rr_sched #(
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [3:0]    ack,
  output logic [1:0]    s,
  output logic [DW-1:0] y,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          busy
);

  localparam int unsigned BCW = $clog2(BURST + 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic           state, state_nxt;
  logic [1:0]     s_nxt;
  logic [1:0]     ptr, ptr_nxt;
  logic [BCW-1:0] beat_cnt, beat_nxt;
  logic           y_valid_nxt;
  logic [DW-1:0]  y_nxt;
  logic           load_en;
  logic           cap_en;
  logic [1:0]     cap_idx;
  logic [DW-1:0]  d_sel;
  logic [3:0]     ack_raw;

  // First requesting index in order base, base+1, base+2, base+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign load_en = !y_valid || y_ready;

  // Next-state, capture decision and register updates.
  always_comb begin
    state_nxt   = state;
    s_nxt       = s;
    ptr_nxt     = ptr;
    beat_nxt    = beat_cnt;
    y_valid_nxt = y_valid;
    cap_en      = 1'b0;
    cap_idx     = s;
    case (state)
      ST_IDLE: begin
        if ((|req) && load_en) begin
          cap_en      = 1'b1;
          cap_idx     = rr_pick(req, ptr);
          s_nxt       = cap_idx;
          beat_nxt    = BCW'(1);
          y_valid_nxt = 1'b1;
          state_nxt   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (load_en) begin
          if (req[s] && (beat_cnt < BCW'(BURST))) begin
            cap_en   = 1'b1;
            cap_idx  = s;
            beat_nxt = BCW'(beat_cnt + 1'b1);
          end else if (|req) begin
            cap_en   = 1'b1;
            cap_idx  = rr_pick(req, s + 2'd1);
            s_nxt    = cap_idx;
            beat_nxt = BCW'(1);
            ptr_nxt  = s + 2'd1;
          end else begin
            y_valid_nxt = 1'b0;
            ptr_nxt     = s + 2'd1;
            state_nxt   = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    d_sel = d0;
    case (cap_idx)
      2'd0: d_sel = d0;
      2'd1: d_sel = d1;
      2'd2: d_sel = d2;
      2'd3: d_sel = d3;
      default: d_sel = d0;
    endcase
  end

  assign y_nxt   = cap_en ? d_sel : y;
  assign ack_raw = cap_en ? (4'b0001 << cap_idx) : 4'b0000;
  // Reset must force ack low even though req may already be asserted.
  assign ack     = ack_raw & {4{rst_n}};
  assign busy    = (state == ST_GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      s        <= 2'd0;
      ptr      <= 2'd0;
      beat_cnt <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      s        <= s_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_nxt;
      y        <= y_nxt;
      y_valid  <= y_valid_nxt;
    end
  end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
Round-robin scheduler that shares one registered 4:1 8-bit data path among four requesters and drives the 2-bit select for the 4:1 mux. Each requester offers data with a level req and receives a per-beat ack. The winner's word goes into an output register with a valid/ready handshake to the downstream consumer. A granted requester may stream up to BURST consecutive beats before it must release the path.

Parameters:
DW, 8, data width of each requester input and of y
BURST, 4, max consecutive beats one requester may transfer per grant (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  req[i]=1: requester i has valid data on d_i
d0  input  DW  requester 0 data
d1  input  DW  requester 1 data
d2  input  DW  requester 2 data
d3  input  DW  requester 3 data
ack  output  4  combinational; ack[i]=1: d_i is captured at this rising edge
s  output  2  registered mux select = current/last granted requester
y  output  DW  registered output data
y_valid  output  1  y holds an undelivered beat
y_ready  input  1  downstream accepts y this cycle
busy  output  1  1 while state is GRANT

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (async, immediate): s=0, y=0, y_valid=0, ack=0 (forced 0 while rst_n=0), ptr=0, beat_cnt=0, state IDLE, busy=0. An in-flight beat is dropped, not delivered.
- load_en = !y_valid | y_ready. Capture happens only on edges where load_en=1.
- Arbitration order: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with req=1 wins.
- IDLE:
  - If any req and load_en: winner w is picked from ptr.
  - ack[w]=1 combinationally. At the edge: s<=w, y<=d_w, y_valid<=1, beat_cnt<=1, go to GRANT.
  - If no req: nothing changes.
- GRANT:
  - y_valid=1 and !y_ready: hold y, s and beat_cnt; ack=0.
  - On y_ready with req[s]=1 and beat_cnt<BURST: continue the burst. ack[s]=1, y<=d_s, beat_cnt+1, y_valid stays 1.
  - On y_ready with burst exhausted or req[s]=0, and any req: re-arbitrate from s+1. Wraparound may pick s again if it is the only requester. ack[w]=1, s<=w, y<=d_w, beat_cnt<=1, ptr<=s+1.
  - On y_ready with no req: y_valid<=0, ptr<=s+1, back to IDLE. s and y keep their last values.
- At most one ack bit is high in any cycle. ack is never high when load_en=0.
- Requester rule: on an edge with ack[i]=1, the requester presents its next word or drops req. The scheduler never re-captures a word.
- Latency: req to y_valid is 1 cycle. Sustained throughput is 1 beat/cycle while y_ready=1.
- Wraparound: ptr and s arithmetic is 2-bit modulo (3+1 -> 0).
- Requester starvation is bounded. A requester is granted within 3*BURST accepted beats.
- req deasserting while the path is stalled has no effect on the held y. The next grant decision uses req at the edge where y_ready=1.

Test Plan:
1. Reset, then req=0001, d0=8'h33, y_ready=1 -> next cycle y=33, y_valid=1, s=0. With req held, beats 2-4 stream. After 4 beats s re-arbitrates to 0 again (only requester) with beat_cnt=1.
2. req=1111 held, d0=33, d1=43, d2=AD, d3=AF, BURST=1, y_ready=1 -> y sequence 33,43,AD,AF,33,...; s=0,1,2,3,0; exactly one ack bit per cycle.
3. req=0100, d2=AD captured, then y_ready=0 for 3 cycles while d2 changes to 8'h11 -> y stays AD, ack=0, s=2. On y_ready=1 the next beat captures 11.
4. ptr=3 with req=1001 -> requester 3 wins first (AF). After its burst ends, requester 0 wins (33): wraparound check.
5. Mid-burst, assert rst_n=0 asynchronously between edges -> y_valid, ack, s, y drop to 0 immediately. After release with req=0010, first grant goes to 1 (ptr=0 search).
6. Single beat then req=0000 with y_ready=1 -> y_valid falls after delivery, busy=0, state IDLE; a later req=1000 is granted from ptr=s+1.
